pc_gen: RTL and testbench



---
 rtl/riscv_pkg.sv | 29 ++
 rtl/pc_gen_if.sv | 37 +++
 rtl/pc_next_sel.sv | 58 +++++
 rtl/pc_gen.sv | 96 +++++++++
 tb/tb_pc_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and default vectors for the PC generation stage.
// State and next-PC select encodings are used by pc_gen and pc_next_sel.
package riscv_pkg;

    typedef enum logic [1:0] {
        RESET,
        BOOT,
        RUN,
        HALT
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BR,
        SEL_JAL,
        SEL_JALR,
        SEL_MRET,
        SEL_TRAP
    } pc_sel_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control-flow request and PC result bundle between the core and pc_gen.
// master = core side driving requests, slave = pc_gen.
interface pc_gen_if;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jal;
    logic [31:0] jal_target;
    logic        jalr;
    logic [31:0] jalr_target;
    logic        trap;
    logic        mret;
    logic [31:0] mepc;
    logic        halt;
    logic        resume;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        misaligned;
    logic [31:0] misaligned_addr;
    logic        halted;

    modport master (
        output stall, branch_taken, branch_target, jal, jal_target,
               jalr, jalr_target, trap, mret, mepc, halt, resume,
        input  pc, pc_plus4, pc_valid, misaligned, misaligned_addr, halted
    );

    modport slave (
        input  stall, branch_taken, branch_target, jal, jal_target,
               jalr, jalr_target, trap, mret, mepc, halt, resume,
        output pc, pc_plus4, pc_valid, misaligned, misaligned_addr, halted
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority encoder, target mux and alignment check.
// A misaligned redirect target is replaced by the trap vector.
module pc_next_sel
    import riscv_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jal,
    input  logic [31:0] jal_target,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    input  logic        trap,
    input  logic        mret,
    input  logic [31:0] mepc,
    output pc_sel_t     sel,
    output logic [31:0] target,
    output logic        target_misaligned,
    output logic [31:0] next_pc
);

    logic redirect;

    // trap and mret outrank stall; every other redirect waits for the stall to clear
    always_comb begin
        sel    = SEL_SEQ;
        target = pc_plus4;
        if (trap) begin
            sel    = SEL_TRAP;
            target = TRAP_VECTOR;
        end else if (mret) begin
            sel    = SEL_MRET;
            target = mepc;
        end else if (stall) begin
            sel    = SEL_HOLD;
            target = pc;
        end else if (jalr) begin
            sel    = SEL_JALR;
            target = jalr_target & 32'hFFFF_FFFE;
        end else if (jal) begin
            sel    = SEL_JAL;
            target = jal_target;
        end else if (branch_taken) begin
            sel    = SEL_BR;
            target = branch_target;
        end
    end

    assign redirect          = (sel == SEL_BR) || (sel == SEL_JAL) ||
                               (sel == SEL_JALR) || (sel == SEL_MRET);
    assign target_misaligned = redirect && !is_word_aligned(target);
    assign next_pc           = target_misaligned ? TRAP_VECTOR : target;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generation: PC register, boot/run/halt sequencing and
// registered misalignment reporting for redirect targets.
module pc_gen
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic      clk,
    input  logic      res,
    pc_gen_if.slave   bus
);

    localparam bit VECTORS_ALIGNED = (RESET_VECTOR[1:0] == 2'b00) &&
                                     (TRAP_VECTOR[1:0] == 2'b00);

    pc_state_t   state;
    pc_sel_t     sel;
    logic [31:0] target;
    logic        target_misaligned;
    logic [31:0] next_pc;

    assign bus.pc_plus4 = bus.pc + 32'd4;

    pc_next_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_sel (
        .pc                (bus.pc),
        .pc_plus4          (bus.pc_plus4),
        .stall             (bus.stall),
        .branch_taken      (bus.branch_taken),
        .branch_target     (bus.branch_target),
        .jal               (bus.jal),
        .jal_target        (bus.jal_target),
        .jalr              (bus.jalr),
        .jalr_target       (bus.jalr_target),
        .trap              (bus.trap),
        .mret              (bus.mret),
        .mepc              (bus.mepc),
        .sel               (sel),
        .target            (target),
        .target_misaligned (target_misaligned),
        .next_pc           (next_pc)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state               <= RESET;
            bus.pc              <= RESET_VECTOR;
            bus.pc_valid        <= 1'b0;
            bus.misaligned      <= 1'b0;
            bus.misaligned_addr <= 32'h0;
            bus.halted          <= 1'b0;
        end else begin
            bus.misaligned      <= 1'b0;
            bus.misaligned_addr <= 32'h0;
            case (state)
                RESET: begin
                    state <= BOOT;
                end
                BOOT: begin
                    state        <= RUN;
                    bus.pc_valid <= 1'b1;
                end
                RUN: begin
                    if (sel != SEL_HOLD) begin
                        bus.pc <= next_pc;
                    end
                    bus.misaligned <= target_misaligned;
                    if (target_misaligned) begin
                        bus.misaligned_addr <= target;
                    end
                    // the redirect of the halting cycle still lands before freezing
                    if (bus.halt) begin
                        state        <= HALT;
                        bus.pc_valid <= 1'b0;
                        bus.halted   <= 1'b1;
                    end
                end
                HALT: begin
                    if (bus.resume && !bus.halt) begin
                        state        <= RUN;
                        bus.pc_valid <= 1'b1;
                        bus.halted   <= 1'b0;
                    end
                end
                default: begin
                    state <= RESET;
                end
            endcase
        end
    end

    a_vectors_aligned: assert property (@(posedge clk) disable iff (res) VECTORS_ALIGNED);

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen: table of single-cycle requests with
// hand-computed PC results, plus reset/boot and async-reset sequences.
module tb_pc_gen;
    import riscv_pkg::*;

    localparam logic [7:0] R_STALL = 8'h01;
    localparam logic [7:0] R_BR    = 8'h02;
    localparam logic [7:0] R_JAL   = 8'h04;
    localparam logic [7:0] R_JALR  = 8'h08;
    localparam logic [7:0] R_TRAP  = 8'h10;
    localparam logic [7:0] R_MRET  = 8'h20;
    localparam logic [7:0] R_HALT  = 8'h40;
    localparam logic [7:0] R_RES   = 8'h80;

    typedef struct {
        logic [7:0]  req;
        logic [31:0] br_t;
        logic [31:0] jal_t;
        logic [31:0] jalr_t;
        logic [31:0] mepc;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [31:0] e_maddr;
        logic        e_halted;
    } vec_t;

    logic clk;
    logic res;
    int   n_cmp;
    int   n_err;
    vec_t vecs[$];

    pc_gen_if bus();

    pc_gen #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.stall         = v.req[0];
        bus.branch_taken  = v.req[1];
        bus.jal           = v.req[2];
        bus.jalr          = v.req[3];
        bus.trap          = v.req[4];
        bus.mret          = v.req[5];
        bus.halt          = v.req[6];
        bus.resume        = v.req[7];
        bus.branch_target = v.br_t;
        bus.jal_target    = v.jal_t;
        bus.jalr_target   = v.jalr_t;
        bus.mepc          = v.mepc;
    endtask

    function automatic vec_t mk(input logic [7:0] req, input logic [31:0] br_t,
                                input logic [31:0] jal_t, input logic [31:0] jalr_t,
                                input logic [31:0] mepc, input logic [31:0] e_pc,
                                input logic e_mis, input logic [31:0] e_maddr,
                                input logic e_halted);
        vec_t v;
        v.req = req; v.br_t = br_t; v.jal_t = jal_t; v.jalr_t = jalr_t; v.mepc = mepc;
        v.e_pc = e_pc; v.e_mis = e_mis; v.e_maddr = e_maddr; v.e_halted = e_halted;
        return v;
    endfunction

    task automatic check_out(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_mis, input logic e_halted);
        chk({tag, " pc"}, bus.pc, e_pc);
        chk({tag, " pc_plus4"}, bus.pc_plus4, e_pc + 32'd4);
        chk({tag, " pc_valid"}, {31'h0, bus.pc_valid}, {31'h0, e_valid});
        chk({tag, " misaligned"}, {31'h0, bus.misaligned}, {31'h0, e_mis});
        chk({tag, " halted"}, {31'h0, bus.halted}, {31'h0, e_halted});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        res   = 1'b1;
        drive(mk(8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));

        //     req                     br_t          jal_t         jalr_t        mepc          e_pc          mis   maddr         halted
        vecs.push_back(mk(8'h00,              32'h0,        32'h0,        32'h0,        32'h0,        32'h4,        1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(8'h00,              32'h0,        32'h0,        32'h0,        32'h0,        32'h8,        1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_BR | R_STALL,     32'h40,       32'h0,        32'h0,        32'h0,        32'h8,        1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_BR,               32'h40,       32'h0,        32'h0,        32'h0,        32'h40,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_JALR,             32'h0,        32'h0,        32'h81,       32'h0,        32'h80,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_JALR,             32'h0,        32'h0,        32'h82,       32'h0,        32'h100,      1'b1, 32'h82, 1'b0));
        vecs.push_back(mk(8'h00,              32'h0,        32'h0,        32'h0,        32'h0,        32'h104,      1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_TRAP|R_JAL|R_STALL, 32'h0,      32'h200,      32'h0,        32'h0,        32'h100,      1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_MRET,             32'h0,        32'h0,        32'h0,        32'h44,       32'h44,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_MRET,             32'h0,        32'h0,        32'h0,        32'h46,       32'h100,      1'b1, 32'h46, 1'b0));
        vecs.push_back(mk(R_JAL,              32'h0,        32'h10,       32'h0,        32'h0,        32'h10,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_JAL | R_STALL,    32'h0,        32'h11,       32'h0,        32'h0,        32'h10,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_JAL,              32'h0,        32'h13,       32'h0,        32'h0,        32'h100,      1'b1, 32'h13, 1'b0));
        vecs.push_back(mk(R_MRET | R_STALL,   32'h0,        32'h0,        32'h0,        32'h1C,       32'h1C,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_JALR|R_JAL|R_BR,  32'h400,      32'h300,      32'h20,       32'h0,        32'h20,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_MRET | R_JALR,    32'h0,        32'h0,        32'h30,       32'h8,        32'h8,        1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_BR,               32'h1E,       32'h0,        32'h0,        32'h0,        32'h100,      1'b1, 32'h1E, 1'b0));
        vecs.push_back(mk(R_JAL,              32'h0,        32'h1C,       32'h0,        32'h0,        32'h1C,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_HALT,             32'h0,        32'h0,        32'h0,        32'h0,        32'h20,       1'b0, 32'h0,  1'b1));
        vecs.push_back(mk(R_TRAP,             32'h0,        32'h0,        32'h0,        32'h0,        32'h20,       1'b0, 32'h0,  1'b1));
        vecs.push_back(mk(8'h00,              32'h0,        32'h0,        32'h0,        32'h0,        32'h20,       1'b0, 32'h0,  1'b1));
        vecs.push_back(mk(R_TRAP | R_JAL,     32'h0,        32'h40,       32'h0,        32'h0,        32'h20,       1'b0, 32'h0,  1'b1));
        vecs.push_back(mk(R_HALT | R_RES,     32'h0,        32'h0,        32'h0,        32'h0,        32'h20,       1'b0, 32'h0,  1'b1));
        vecs.push_back(mk(R_TRAP,             32'h0,        32'h0,        32'h0,        32'h0,        32'h20,       1'b0, 32'h0,  1'b1));
        vecs.push_back(mk(R_RES,              32'h0,        32'h0,        32'h0,        32'h0,        32'h20,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(8'h00,              32'h0,        32'h0,        32'h0,        32'h0,        32'h24,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_HALT | R_JAL,     32'h0,        32'h50,       32'h0,        32'h0,        32'h50,       1'b0, 32'h0,  1'b1));
        vecs.push_back(mk(R_RES | R_BR,       32'h80,       32'h0,        32'h0,        32'h0,        32'h50,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(8'h00,              32'h0,        32'h0,        32'h0,        32'h0,        32'h54,       1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_JAL,              32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0,        32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0));
        vecs.push_back(mk(8'h00,              32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'h0,  1'b0));
        vecs.push_back(mk(R_HALT | R_JALR,    32'h0,        32'h0,        32'h7,        32'h0,        32'h100,      1'b1, 32'h6,  1'b1));
        vecs.push_back(mk(R_RES,              32'h0,        32'h0,        32'h0,        32'h0,        32'h100,      1'b0, 32'h0,  1'b0));

        // reset held across edges, then release into BOOT and RUN
        tick();
        tick();
        check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset misaligned_addr", bus.misaligned_addr, 32'h0);
        res = 1'b0;
        tick();
        check_out("boot", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("run0", 32'h0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            tick();
            check_out($sformatf("v%0d", i), vecs[i].e_pc, !vecs[i].e_halted,
                      vecs[i].e_mis, vecs[i].e_halted);
            if (vecs[i].e_mis) begin
                chk($sformatf("v%0d misaligned_addr", i), bus.misaligned_addr, vecs[i].e_maddr);
            end
        end

        // misaligned pulse lasts one cycle even if the next request is a stall
        drive(mk(R_JAL, 32'h0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
        tick();
        check_out("mis_pulse", 32'h100, 1'b1, 1'b1, 1'b0);
        drive(mk(R_STALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
        tick();
        check_out("mis_clear", 32'h100, 1'b1, 1'b0, 1'b0);

        // asynchronous reset between edges while a misaligned pulse is visible
        drive(mk(R_JAL, 32'h0, 32'h21, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
        tick();
        check_out("pre_async", 32'h100, 1'b1, 1'b1, 1'b0);
        drive(mk(R_JAL, 32'h0, 32'h60, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
        tick();
        #2;
        res = 1'b1;
        #1;
        check_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        drive(mk(8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
        tick();
        res = 1'b0;
        tick();
        check_out("reboot", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("rerun0", 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("rerun1", 32'h4, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
